// File: rtl/fust_m_issue_pkg.sv
// Shared types for the matrix FUST issue slice: row layout, op codes, FSM states.
// Register index width is derived from the tracked matrix register count.
package fust_m_issue_pkg;

  localparam int MREG_NUM   = 16;
  localparam int MREG_IDX_W = $clog2(MREG_NUM);

  typedef logic [MREG_IDX_W-1:0] mreg_idx_t;

  typedef enum logic [2:0] {
    MOP_MMUL   = 3'd0,
    MOP_MADD   = 3'd1,
    MOP_MTRANS = 3'd2,
    MOP_MLOAD  = 3'd3,
    MOP_MSTORE = 3'd4
  } mop_e;

  typedef struct packed {
    mop_e      op;
    mreg_idx_t md;
    mreg_idx_t ms1;
    mreg_idx_t ms2;
    mreg_idx_t ms3;
  } fust_m_row_t;

  typedef struct packed {
    logic        busy;
    fust_m_row_t row;
  } fust_m_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_EXEC  = 2'd3
  } issue_m_state_t;

endpackage

// File: rtl/fust_m_issue_if.sv
// FUST-row and matrix-unit handshake bundle seen by the issue block.
// master = issue block, slave = FUST/matrix-unit side.
interface fust_m_issue_if;
  import fust_m_issue_pkg::*;

  fust_m_t     fust;
  logic        busy;
  logic        fu_ready;
  logic        fu_done;
  logic        issue_valid;
  fust_m_row_t issue_row;

  modport master (
    input  fust, fu_ready, fu_done,
    output busy, issue_valid, issue_row
  );

  modport slave (
    output fust, fu_ready, fu_done,
    input  busy, issue_valid, issue_row
  );

endinterface

// File: rtl/fust_m_issue_mreg_hazard_chk.sv
// Combinational pending-mask lookup for md and three sources; 0-cycle latency.
// hazard_free is high only when none of the four referenced registers is pending.
module fust_m_issue_mreg_hazard_chk
  import fust_m_issue_pkg::*;
#(
  parameter int NUM_MREGS = MREG_NUM
) (
  input  logic [NUM_MREGS-1:0] pending,
  input  mreg_idx_t            md,
  input  mreg_idx_t            ms1,
  input  mreg_idx_t            ms2,
  input  mreg_idx_t            ms3,
  output logic                 hazard_free
);

  assign hazard_free = ~(pending[md] | pending[ms1] | pending[ms2] | pending[ms3]);

endmodule

// File: rtl/fust_m_issue.sv
// Matrix FUST issue: waits for operand registers, launches into the matrix unit, retires on done.
// Row valid to launch strobe is 2 cycles minimum; holds in WAIT while hazards or !fu_ready.
module fust_m_issue
  import fust_m_issue_pkg::*;
#(
  parameter int NUM_MREGS      = MREG_NUM,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  fust_m_issue_if.master       io,
  input  logic [NUM_MREGS-1:0] mreg_pending,
  input  logic                 flush,
  output logic                 set_pend_en,
  output logic                 clr_pend_en,
  output mreg_idx_t            pend_reg,
  output logic                 timeout_err
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMATCH  = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  issue_m_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             hazard_free;

  fust_m_issue_mreg_hazard_chk #(
    .NUM_MREGS (NUM_MREGS)
  ) u_hazard (
    .pending     (mreg_pending),
    .md          (io.fust.row.md),
    .ms1         (io.fust.row.ms1),
    .ms2         (io.fust.row.ms2),
    .ms3         (io.fust.row.ms3),
    .hazard_free (hazard_free)
  );

  // The latched row owns pend_reg so set and clear always name the same register.
  assign set_pend_en = io.issue_valid;
  assign clr_pend_en = (state == S_EXEC) && io.fu_done;
  assign pend_reg    = io.issue_row.md;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      io.busy        <= 1'b0;
      io.issue_valid <= 1'b0;
      io.issue_row   <= '0;
      cnt            <= '0;
      timeout_err    <= 1'b0;
    end else begin
      io.issue_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io.fust.busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush || !io.fust.busy) begin
            state <= S_IDLE;
          end else if (hazard_free && io.fu_ready) begin
            state          <= S_ISSUE;
            io.issue_valid <= 1'b1;
            io.busy        <= 1'b1;
            io.issue_row   <= io.fust.row;
            cnt            <= '0;
          end
        end
        S_ISSUE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          // Done takes priority over a same-cycle watchdog match.
          if (io.fu_done) begin
            state   <= S_IDLE;
            io.busy <= 1'b0;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (WD_EN && (cnt == TMATCH)) timeout_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fust_m_issue.sv
// Scoreboard bench for fust_m_issue: stimulus queues expected launch/retire events, a monitor checks them.
module tb_fust_m_issue;
  import fust_m_issue_pkg::*;

  logic                clk;
  logic                rst;
  logic [MREG_NUM-1:0] mreg_pending;
  logic                flush;
  logic                set_pend_en;
  logic                clr_pend_en;
  mreg_idx_t           pend_reg;
  logic                timeout_err;

  fust_m_issue_if io ();

  fust_m_issue #(
    .NUM_MREGS      (MREG_NUM),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (io),
    .mreg_pending (mreg_pending),
    .flush        (flush),
    .set_pend_en  (set_pend_en),
    .clr_pend_en  (clr_pend_en),
    .pend_reg     (pend_reg),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    bit          clr;
    int          cyc;
    mreg_idx_t   md;
    fust_m_row_t row;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  nvec = 0;
  int  nerr = 0;
  int  cyc  = 0;
  int  t0;
  int  iss_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input bit clr, input int c, input mreg_idx_t md, input fust_m_row_t r);
    ev_t e;
    e.clr = clr; e.cyc = c; e.md = md; e.row = r;
    exp_q.push_back(e);
  endfunction

  function automatic fust_m_row_t mk_row(input mop_e op, input int md, input int s1, input int s2, input int s3);
    fust_m_row_t r;
    r.op  = op;
    r.md  = mreg_idx_t'(md);
    r.ms1 = mreg_idx_t'(s1);
    r.ms2 = mreg_idx_t'(s2);
    r.ms3 = mreg_idx_t'(s3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input fust_m_row_t r);
    io.fust.busy = 1'b1;
    io.fust.row  = r;
    t0 = cyc;
  endtask

  // FUST frees its row as soon as busy rises.
  task automatic wait_busy(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (io.busy) begin
        iss_cyc = cyc;
        io.fust.busy = 1'b0;
        return;
      end
    end
    check("wait_busy_bound", 32'(io.busy), 32'd1);
    io.fust.busy = 1'b0;
    iss_cyc = cyc;
  endtask

  // Done arrives in the n-th EXEC cycle.
  task automatic finish_exec(input int n, input mreg_idx_t md);
    repeat (n) tick();
    io.fu_done = 1'b1;
    push_ev(1'b1, cyc, md, '0);
    tick();
    io.fu_done = 1'b0;
    check("retire_busy_low", 32'(io.busy), 32'd0);
  endtask

  task automatic run_op(input fust_m_row_t r, input int stall_bit, input int stall_len, input int exec_n);
    if (stall_len > 0) mreg_pending[stall_bit] = 1'b1;
    present(r);
    push_ev(1'b0, (stall_len + 1 > 2) ? t0 + stall_len + 1 : t0 + 2, r.md, r);
    repeat (stall_len) tick();
    mreg_pending = '0;
    wait_busy(stall_len + 6);
    finish_exec(exec_n, r.md);
  endtask

  fust_m_row_t ra, rb;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (io.issue_valid || clr_pend_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, io.issue_valid, clr_pend_en}, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("ev_kind", 32'(clr_pend_en), 32'(mon_e.clr));
            check("ev_cycle", 32'(cyc), 32'(mon_e.cyc));
            check("ev_pend_reg", 32'(pend_reg), 32'(mon_e.md));
            if (!mon_e.clr) begin
              check("issue_row", 32'(io.issue_row), 32'(mon_e.row));
              check("set_pend_en", 32'(set_pend_en), 32'd1);
            end else begin
              check("clr_busy_high", 32'(io.busy), 32'd1);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
      end
    join_none

    // 1: reset holds everything low even with a valid row present
    rst = 1'b1; flush = 1'b0; mreg_pending = '0;
    io.fu_ready = 1'b1; io.fu_done = 1'b0;
    io.fust.busy = 1'b1;
    io.fust.row  = mk_row(MOP_MADD, 5, 6, 7, 8);
    repeat (3) tick();
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_issue_valid", 32'(io.issue_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_issue_row", 32'(io.issue_row), 32'd0);
    check("rst_pend_reg", 32'(pend_reg), 32'd0);
    io.fust.busy = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(io.busy), 32'd0);

    // 2: simple issue, done on the 8th EXEC cycle (also the watchdog boundary)
    ra = mk_row(MOP_MMUL, 3, 1, 2, 4);
    run_op(ra, 0, 0, 8);
    check("issue_latency", 32'(iss_cyc - t0), 32'd2);
    check("done_on_8th_no_err", 32'(timeout_err), 32'd0);

    // 3: RAW stall on ms2, then aliased sources/dest gated by one bit
    ra = mk_row(MOP_MADD, 5, 0, 2, 6);
    run_op(ra, 2, 5, 3);
    ra = mk_row(MOP_MTRANS, 6, 6, 6, 6);
    run_op(ra, 6, 3, 2);

    // 4a: flush in WAIT squashes; stray fu_done in IDLE ignored
    ra = mk_row(MOP_MLOAD, 7, 0, 0, 0);
    present(ra);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; io.fust.busy = 1'b0; io.fu_done = 1'b1;
    check("flush_no_busy", 32'(io.busy), 32'd0);
    tick();
    io.fu_done = 1'b0;
    check("flush_idle", 32'(io.busy), 32'd0);
    tick();

    // 4b: flush during ISSUE/EXEC is ignored
    ra = mk_row(MOP_MSTORE, 9, 1, 1, 9);
    present(ra);
    push_ev(1'b0, t0 + 2, ra.md, ra);
    wait_busy(6);
    flush = 1'b1;
    finish_exec(4, ra.md);
    flush = 1'b0;

    // 5: watchdog fires after 8 EXEC cycles, stays EXEC, sticky past done
    ra = mk_row(MOP_MMUL, 10, 11, 12, 13);
    present(ra);
    push_ev(1'b0, t0 + 2, ra.md, ra);
    wait_busy(6);
    repeat (8) tick();
    check("wd_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("wd_fired", 32'(timeout_err), 32'd1);
    check("wd_still_busy", 32'(io.busy), 32'd1);
    tick();
    finish_exec(1, ra.md);
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // 6: back-to-back rows, then async reset mid-EXEC
    ra = mk_row(MOP_MADD, 11, 0, 1, 2);
    rb = mk_row(MOP_MMUL, 12, 3, 4, 5);
    run_op(ra, 0, 0, 2);
    present(rb);
    push_ev(1'b0, t0 + 2, rb.md, rb);
    wait_busy(6);
    check("b2b_latency", 32'(iss_cyc - t0), 32'd2);
    repeat (2) tick();
    #2;
    rst = 1'b1; io.fu_done = 1'b1;
    #1;
    check("async_rst_busy", 32'(io.busy), 32'd0);
    check("async_rst_clr", 32'(clr_pend_en), 32'd0);
    check("async_rst_wd", 32'(timeout_err), 32'd0);
    tick();
    rst = 1'b0; io.fu_done = 1'b0;
    tick();
    check("post_async_rst_idle", 32'(io.busy), 32'd0);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
